virtual_ds2431_rom_ctrl: RTL

VIRTUAL_DS2431_ROM_CTRL -- requirements
Module: VirtualDS2431_RomCtrl

---
 rtl/virtual_ds2431_rom_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/virtual_ds2431_rom_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : virtual_ds2431_rom_ctrl
// Description : 1-Wire ROM-layer controller for a virtual DS2431. It follows
//               bus resets and presence, decodes ROM commands, serves Read ROM
//               and Match ROM, and then hands the byte interface over to the
//               function layer.
// Revision    : 1.0 - initial release
// ============================================================================
module virtual_ds2431_rom_ctrl #(
    parameter bit RESUME_EN = 1'b1
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [63:0] romId,
    output logic        io_trig,
    output logic        io_nRxTx,
    output logic [7:0]  io_sentDat,
    input  logic [7:0]  io_receiveDat,
    input  logic        io_done,
    input  logic        io_nBusRst,
    input  logic        io_nODBusRst,
    input  logic        io_bus,
    output logic        odMode,
    output logic        fnActive,
    output logic [7:0]  romCmd,
    input  logic        fn_trig,
    input  logic        fn_nRxTx,
    input  logic [7:0]  fn_sentDat,
    output logic        fn_done,
    output logic [7:0]  fn_receiveDat
);

    localparam logic [7:0] c_CMD_READ     = 8'h33;
    localparam logic [7:0] c_CMD_MATCH    = 8'h55;
    localparam logic [7:0] c_CMD_SKIP     = 8'hCC;
    localparam logic [7:0] c_CMD_OD_SKIP  = 8'h3C;
    localparam logic [7:0] c_CMD_OD_MATCH = 8'h69;
    localparam logic [7:0] c_CMD_RESUME   = 8'hA5;
    localparam logic [2:0] c_LAST_BYTE    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_PRES = 3'd1,
        ST_CMD       = 3'd2,
        ST_CMD_WAIT  = 3'd3,
        ST_MATCH     = 3'd4,
        ST_READ      = 3'd5,
        ST_FUNC      = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;

    // Registered IO-block flags and their one-cycle-delayed copies.
    logic       r_ioDone, r_ioDonePrev;
    logic       r_ioBus, r_ioBusPrev;
    logic       r_nBusRst, r_nBusRstPrev;
    logic       r_nODBusRst, r_nODBusRstPrev;

    logic       r_odMode, w_odModeNext;
    logic       r_resume, w_resumeNext;
    logic [7:0] r_romCmd, w_romCmdNext;
    logic [2:0] r_byteCnt, w_byteCntNext;
    // Set while a READ/MATCH byte has been triggered and its byteDone is pending.
    logic       r_busy, w_busyNext;

    logic       w_byteDone;
    logic       w_busRise;
    logic       w_stdRst;
    logic       w_odRst;
    logic [7:0] w_romByte;

    assign w_byteDone = r_ioDone & ~r_ioDonePrev;
    assign w_busRise  = r_ioBus & ~r_ioBusPrev;
    assign w_stdRst   = ~r_nBusRst & r_nBusRstPrev;
    assign w_odRst    = ~r_nODBusRst & r_nODBusRstPrev;
    assign w_romByte  = romId[{r_byteCnt, 3'b000} +: 8];

    assign odMode = r_odMode;
    assign romCmd = r_romCmd;

    // Capture the IO flags; preload to 1 so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_ioDone        <= 1'b1;
            r_ioDonePrev    <= 1'b1;
            r_ioBus         <= 1'b1;
            r_ioBusPrev     <= 1'b1;
            r_nBusRst       <= 1'b1;
            r_nBusRstPrev   <= 1'b1;
            r_nODBusRst     <= 1'b1;
            r_nODBusRstPrev <= 1'b1;
        end else begin
            r_ioDone        <= io_done;
            r_ioDonePrev    <= r_ioDone;
            r_ioBus         <= io_bus;
            r_ioBusPrev     <= r_ioBus;
            r_nBusRst       <= io_nBusRst;
            r_nBusRstPrev   <= r_nBusRst;
            r_nODBusRst     <= io_nODBusRst;
            r_nODBusRstPrev <= r_nODBusRst;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Controller context: speed, resume flag, last command and byte progress.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_odMode  <= 1'b0;
            r_resume  <= 1'b0;
            r_romCmd  <= 8'h00;
            r_byteCnt <= 3'd0;
            r_busy    <= 1'b0;
        end else begin
            r_odMode  <= w_odModeNext;
            r_resume  <= w_resumeNext;
            r_romCmd  <= w_romCmdNext;
            r_byteCnt <= w_byteCntNext;
            r_busy    <= w_busyNext;
        end
    end

    // Next-state, context updates and IO/function-layer routing.
    always_comb begin
        w_stateNext   = r_state;
        w_odModeNext  = r_odMode;
        w_resumeNext  = r_resume;
        w_romCmdNext  = r_romCmd;
        w_byteCntNext = r_byteCnt;
        w_busyNext    = r_busy;
        io_trig       = 1'b0;
        io_nRxTx      = 1'b0;
        io_sentDat    = 8'h00;
        fnActive      = 1'b0;
        fn_done       = 1'b0;
        fn_receiveDat = 8'h00;

        case (r_state)
            ST_IDLE: begin
                w_stateNext = ST_IDLE;
            end
            ST_WAIT_PRES: begin
                // Rising bus level marks the end of our presence pulse.
                if (w_busRise) begin
                    w_stateNext = ST_CMD;
                end
            end
            ST_CMD: begin
                io_trig     = 1'b1;
                io_nRxTx    = 1'b0;
                w_stateNext = ST_CMD_WAIT;
            end
            ST_CMD_WAIT: begin
                if (w_byteDone) begin
                    w_romCmdNext  = io_receiveDat;
                    w_byteCntNext = 3'd0;
                    w_busyNext    = 1'b0;
                    case (io_receiveDat)
                        c_CMD_READ: begin
                            w_resumeNext = 1'b0;
                            w_stateNext  = ST_READ;
                        end
                        c_CMD_MATCH: begin
                            w_stateNext = ST_MATCH;
                        end
                        c_CMD_SKIP: begin
                            w_resumeNext = 1'b0;
                            w_stateNext  = ST_FUNC;
                        end
                        c_CMD_OD_SKIP: begin
                            w_odModeNext = 1'b1;
                            w_resumeNext = 1'b0;
                            w_stateNext  = ST_FUNC;
                        end
                        c_CMD_OD_MATCH: begin
                            w_odModeNext = 1'b1;
                            w_stateNext  = ST_MATCH;
                        end
                        c_CMD_RESUME: begin
                            if (RESUME_EN && r_resume) begin
                                w_stateNext = ST_FUNC;
                            end else begin
                                w_stateNext = ST_HALT;
                            end
                        end
                        default: begin
                            w_stateNext = ST_HALT;
                        end
                    endcase
                end
            end
            ST_READ: begin
                io_nRxTx   = 1'b1;
                io_sentDat = w_romByte;
                if (!r_busy) begin
                    io_trig    = 1'b1;
                    w_busyNext = 1'b1;
                end else if (w_byteDone) begin
                    w_busyNext = 1'b0;
                    if (r_byteCnt == c_LAST_BYTE) begin
                        w_stateNext = ST_FUNC;
                    end else begin
                        w_byteCntNext = r_byteCnt + 3'd1;
                    end
                end
            end
            ST_MATCH: begin
                io_nRxTx = 1'b0;
                if (!r_busy) begin
                    io_trig    = 1'b1;
                    w_busyNext = 1'b1;
                end else if (w_byteDone) begin
                    w_busyNext = 1'b0;
                    if (io_receiveDat != w_romByte) begin
                        // Not addressed: drop out and only an OD match reverts speed.
                        w_resumeNext = 1'b0;
                        if (r_romCmd == c_CMD_OD_MATCH) begin
                            w_odModeNext = 1'b0;
                        end
                        w_stateNext = ST_HALT;
                    end else if (r_byteCnt == c_LAST_BYTE) begin
                        w_resumeNext = 1'b1;
                        w_stateNext  = ST_FUNC;
                    end else begin
                        w_byteCntNext = r_byteCnt + 3'd1;
                    end
                end
            end
            ST_FUNC: begin
                fnActive      = 1'b1;
                io_trig       = fn_trig;
                io_nRxTx      = fn_nRxTx;
                io_sentDat    = fn_sentDat;
                fn_done       = io_done;
                fn_receiveDat = io_receiveDat;
            end
            ST_HALT: begin
                w_stateNext = ST_HALT;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase

        // A bus reset overrides anything decided above in the same cycle.
        if (w_stdRst || w_odRst) begin
            w_stateNext   = ST_WAIT_PRES;
            w_resumeNext  = r_resume;
            w_romCmdNext  = r_romCmd;
            w_byteCntNext = 3'd0;
            w_busyNext    = 1'b0;
            io_trig       = 1'b0;
            w_odModeNext  = w_stdRst ? 1'b0 : r_odMode;
        end
    end

endmodule
`default_nettype wire
